// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, diff = (a - b - b_in) mod 2^WIDTH.
// One full-subtractor slice plus a borrow flop processes one bit per clock,
// LSB first, behind a start/busy/done handshake.
// Optional build macro SERIAL_SUB_SAT_EN: clamp diff to 0 on underflow
// (b_out still reports the borrow).
module serial_sub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] r_q;
   logic             br_q;
   logic [WIDTH-1:0] diff_q;
   logic             b_out_q;

   logic             bit_d;
   logic             br_d;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] result_d;
   logic             last_bit;

   // Full-subtractor slice on the current LSBs and the next result value.
   always_comb begin
      bit_d    = a_q[0] ^ b_q[0] ^ br_q;
      br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      r_d      = {bit_d, r_q[WIDTH-1:1]};
      last_bit = (cnt_q == CNT_W'(WIDTH - 1));
      result_d = r_d;
`ifdef SERIAL_SUB_SAT_EN
      // Underflow clamps to zero; the borrow still goes out on b_out.
      if (br_d) begin
         result_d = '0;
      end
`endif
   end

   // Sequencer: IDLE -> RUN for WIDTH bits -> one-cycle DONE -> IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StRun: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: operand capture, serial shifting, and result hand-off on DONE entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         br_q    <= 1'b0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
      end else begin
         if (state_q == StIdle) begin
            if (start) begin
               a_q  <= a;
               b_q  <= b;
               br_q <= b_in;
               r_q  <= '0;
            end
         end else if (state_q == StRun) begin
            a_q  <= a_q >> 1;
            b_q  <= b_q >> 1;
            br_q <= br_d;
            r_q  <= r_d;
            if (last_bit) begin
               diff_q  <= result_d;
               b_out_q <= br_d;
            end
         end
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign diff  = diff_q;
   assign b_out = b_out_q;

endmodule
